// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: sizes, Rcon table, FSM encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES256_NR  = 14;
    localparam int unsigned AES256_NRK = 15;
    localparam int unsigned KEY_W      = 256;
    localparam int unsigned RK_W       = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RND_W      = 4;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;

    // A round key viewed as four words, w0 in the most significant position.
    typedef struct packed {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } rk_words_t;

    localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = b;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [RK_W-1:0] inv_mix_key(input logic [RK_W-1:0] k);
        logic [RK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_col(k[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes256_ks_step.sv
// One AES-256 key-expansion step: rk[n] from rk[n-2], rk[n-1] and step index n.
module aes256_ks_step
    import aes_pkg::*;
(
    input  logic [RK_W-1:0]  prev2_i,
    input  logic [RK_W-1:0]  prev1_i,
    input  logic [RND_W-1:0] n_i,
    output logic [RK_W-1:0]  next_o
);

    logic [WORD_W-1:0] t_last;
    logic [WORD_W-1:0] sb_in;
    logic [WORD_W-1:0] t;
    rk_words_t         p2;
    rk_words_t         nx;

    // Even steps rotate and add Rcon; odd steps only substitute. One shared set of four S-boxes.
    always_comb begin
        p2     = prev2_i;
        t_last = prev1_i[WORD_W-1:0];
        sb_in  = n_i[0] ? t_last : {t_last[23:0], t_last[31:24]};
        t      = sub_word(sb_in) ^ (n_i[0] ? 32'h0 : {RCON[n_i[3:1]], 24'h0});
        nx.w0  = p2.w0 ^ t;
        nx.w1  = p2.w1 ^ nx.w0;
        nx.w2  = p2.w2 ^ nx.w1;
        nx.w3  = p2.w3 ^ nx.w2;
    end

    assign next_o = nx;

endmodule

// File: rtl/aes256_key_sched.sv
// AES-256 key-expansion engine with a 15-entry round-key file and forward/reverse read port.
// Optional AES256_EQ_INV_KEY_EN: InvMixColumns on inverse reads of keys 1..13.
module aes256_key_sched
    import aes_pkg::*;
#(
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             keys_valid,
    input  logic [RND_W-1:0] rd_round,
    input  logic             inv_en,
    output logic [RK_W-1:0]  round_key
);

    ks_state_e        state_q;
    logic [RND_W-1:0] n_q;
    logic             keys_valid_q;
    logic             key_ready_q;
    logic [RK_W-1:0]  rk_q [AES256_NRK];
    logic [RK_W-1:0]  rk_m2;
    logic [RK_W-1:0]  rk_m1;
    logic [RK_W-1:0]  rk_step_d;

    always_comb begin
        rk_m2 = rk_q[RND_W'(n_q - 4'd2)];
        rk_m1 = rk_q[RND_W'(n_q - 4'd1)];
    end

    aes256_ks_step u_step (
        .prev2_i (rk_m2),
        .prev1_i (rk_m1),
        .n_i     (n_q),
        .next_o  (rk_step_d)
    );

    // Steps 2..14 write one key per cycle; the cycle after step 14 publishes the set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            rk_q         <= '{default: '0};
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (key_valid && key_ready_q) begin
                        rk_q[0]      <= key_in[255:128];
                        rk_q[1]      <= key_in[127:0];
                        n_q          <= 4'd2;
                        keys_valid_q <= 1'b0;
                        key_ready_q  <= 1'b0;
                        state_q      <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (n_q <= RND_W'(AES256_NR)) begin
                        rk_q[n_q] <= rk_step_d;
                        n_q       <= n_q + 4'd1;
                    end else begin
                        keys_valid_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign keys_valid = keys_valid_q;
    assign key_ready  = key_ready_q;

    logic             rd_in_range;
    logic [RND_W-1:0] rd_idx;
    logic [RK_W-1:0]  rd_raw;
    logic [RK_W-1:0]  rd_data;

    always_comb begin
        rd_in_range = (rd_round <= RND_W'(AES256_NR));
        rd_idx      = '0;
        if (rd_in_range) rd_idx = inv_en ? RND_W'(RND_W'(AES256_NR) - rd_round) : rd_round;
        rd_raw  = rk_q[rd_idx];
        rd_data = '0;
`ifdef AES256_EQ_INV_KEY_EN
        if (keys_valid_q && rd_in_range) begin
            rd_data = (inv_en && rd_idx != '0 && rd_idx != RND_W'(AES256_NR)) ? inv_mix_key(rd_raw) : rd_raw;
        end
`else
        if (keys_valid_q && rd_in_range) rd_data = rd_raw;
`endif
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [RK_W-1:0] round_key_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) round_key_q <= '0;
                else     round_key_q <= rd_data;
            end
            assign round_key = round_key_q;
        end else begin : g_out_comb
            assign round_key = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_aes256_key_sched.sv
// Directed self-checking bench for aes256_key_sched: word-level FIPS-197 model with a read scoreboard.
module tb_aes256_key_sched;

    localparam logic [255:0] KEY_A3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_Z  = 256'h0;

    localparam logic [7:0] SBOX_T [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk;
    logic         rst;
    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rd_round;
    logic         inv_en;
    logic [127:0] round_key;

    aes256_key_sched #(.OUT_REG(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rd_round   (rd_round),
        .inv_en     (inv_en),
        .round_key  (round_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] m_rk [15];
    bit           kv_exp = 1'b0;
    logic [127:0] exp_q [$];
    string        tag_q [$];

    function automatic logic [31:0] m_sub_word(input logic [31:0] x);
        return {SBOX_T[x[31:24]], SBOX_T[x[23:16]], SBOX_T[x[15:8]], SBOX_T[x[7:0]]};
    endfunction

    // Textbook FIPS-197 word recurrence over w[0..59].
    task automatic model_expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] tmp;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0)      tmp = m_sub_word({tmp[23:0], tmp[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) tmp = m_sub_word(tmp);
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

`ifdef AES256_EQ_INV_KEY_EN
    function automatic logic [7:0] m_gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] m_imc_key(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++)
                r[127-32*c-8*i -: 8] = m_gm(a[0], m[(4-i)%4]) ^ m_gm(a[1], m[(5-i)%4]) ^
                                       m_gm(a[2], m[(6-i)%4]) ^ m_gm(a[3], m[(7-i)%4]);
        end
        return r;
    endfunction
`endif

    function automatic logic [127:0] exp_read(input int r, input bit inv);
        int           idx;
        logic [127:0] v;
        if (!kv_exp || r > 14) return '0;
        idx = inv ? 14 - r : r;
        v   = m_rk[idx];
`ifdef AES256_EQ_INV_KEY_EN
        if (inv && idx >= 1 && idx <= 13) v = m_imc_key(v);
`endif
        return v;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: drive a read request and queue its expectation; sample pops and compares.
    task automatic drive_read(input int r, input bit inv, input logic [127:0] exp, input string tag);
        rd_round = 4'(r);
        inv_en   = inv;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sample_read();
        #1;
        chk128(tag_q.pop_front(), round_key, exp_q.pop_front());
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            drive_read(r, 1'b0, exp_read(r, 1'b0), $sformatf("%s_fwd%0d", tag, r));
            sample_read();
            drive_read(r, 1'b1, exp_read(r, 1'b1), $sformatf("%s_inv%0d", tag, r));
            sample_read();
        end
        @(negedge clk);
        drive_read(15, 1'b0, 128'h0, $sformatf("%s_rd15_fwd", tag));
        sample_read();
        drive_read(15, 1'b1, 128'h0, $sformatf("%s_rd15_inv", tag));
        sample_read();
    endtask

    // Accept a key and check the 14-edge latency; optionally offer another key while busy.
    task automatic run_expand(input string tag, input logic [255:0] k, input bit inject, input logic [255:0] k2);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        kv_exp    = 1'b0;
        chk1({tag, "_accept_kv"}, keys_valid, 1'b0);
        chk1({tag, "_accept_kr"}, key_ready, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("%s_kv_e%0d", tag, e), keys_valid, e == 14);
            chk1($sformatf("%s_kr_e%0d", tag, e), key_ready, e == 14);
            if (e == 3) begin
                drive_read(2, 1'b0, 128'h0, {tag, "_rd_busy"});
                sample_read();
            end
            if (inject && e == 5) begin
                key_in    = k2;
                key_valid = 1'b1;
            end
            if (e == 6) key_valid = 1'b0;
        end
        kv_exp = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rd_round  = '0;
        inv_en    = 1'b0;
        #2;
        chk1("rst_kv", keys_valid, 1'b0);
        chk1("rst_kr", key_ready, 1'b1);
        drive_read(0, 1'b0, 128'h0, "rst_rk");
        sample_read();
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 A.3 key
        model_expand(KEY_A3);
        run_expand("a3", KEY_A3, 1'b0, KEY_Z);
        @(negedge clk);
        drive_read(0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, "a3_rk0");   sample_read();
        drive_read(2, 1'b0, 128'ha573c29fa176c498a97fce93a572c09c, "a3_rk2");   sample_read();
        drive_read(3, 1'b0, 128'h1651a8cd0244beda1a5da4c10640bade, "a3_rk3");   sample_read();
        drive_read(14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36, "a3_rk14"); sample_read();
        drive_read(0, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36, "a3_inv0"); sample_read();
        drive_read(14, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, "a3_inv14"); sample_read();
        read_all("a3");

        // Rekey from DONE with the zero key; A.3 offered mid-expansion must be ignored
        model_expand(KEY_Z);
        run_expand("z", KEY_Z, 1'b1, KEY_A3);
        @(negedge clk);
        drive_read(1, 1'b0, 128'h0, "z_rk1"); sample_read();
        drive_read(2, 1'b0, 128'h62636363626363636263636362636363, "z_rk2"); sample_read();
        read_all("z");

        // Reset pulse while step 7 is pending
        @(negedge clk);
        key_in    = KEY_A3;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst    = 1'b1;
        kv_exp = 1'b0;
        #1;
        chk1("rstmid_kv", keys_valid, 1'b0);
        chk1("rstmid_kr", key_ready, 1'b1);
        drive_read(14, 1'b0, 128'h0, "rstmid_rk");
        sample_read();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("rstrel_kv", keys_valid, 1'b0);
        chk1("rstrel_kr", key_ready, 1'b1);

        model_expand(KEY_A3);
        run_expand("re", KEY_A3, 1'b0, KEY_Z);
        @(negedge clk);
        drive_read(14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36, "re_rk14"); sample_read();
        read_all("re");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
